// File: rtl/irq_src_pkg.sv
// rtl/irq_src_pkg.sv - shared types and default sizing for the interrupt source controller
package irq_src_pkg;

  typedef enum logic [1:0] {IDLE, REQ, GAP} irq_line_state_t;

  localparam int DEF_N_LINES    = 8;
  localparam int DEF_CNT_W      = 4;
  localparam int DEF_GAP_CYCLES = 2;

endpackage

// File: rtl/irq_src_line.sv
// rtl/irq_src_line.sv - one interrupt line: request FSM, saturating event counter, overflow flag
module irq_src_line
  import irq_src_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             event_i,
  input  logic             clear_i,
  input  logic             int_fin_i,
  input  logic             mask_i,
  output logic             int_req_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] pending_o
);

  localparam int              GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [GW-1:0]    GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [GW-1:0]    GAP_LAST = GW'(1);

  irq_line_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             ovf_q, ovf_d;
  logic             req_q;
  logic             fin_acc;

  always_comb begin
    fin_acc = (state_q == REQ) && int_fin_i;
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      gap_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      // An event paired with an accepted fin nets to zero and can never overflow.
      if (event_i && !fin_acc) begin
        if (cnt_q == CNT_MAX) ovf_d = 1'b1;
        else                  cnt_d = cnt_q + 1'b1;
      end else if (!event_i && fin_acc) begin
        cnt_d = cnt_q - 1'b1;
      end
      case (state_q)
        IDLE: if (cnt_d != '0 && !mask_i) state_d = REQ;
        REQ: begin
          if (fin_acc) begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
          end
        end
        GAP: begin
          gap_d = gap_q - 1'b1;
          if (gap_q == GAP_LAST) state_d = (cnt_d != '0 && !mask_i) ? REQ : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      ovf_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ovf_q   <= ovf_d;
      req_q   <= (state_d == REQ);
    end
  end

  assign int_req_o  = req_q;
  assign overflow_o = ovf_q;
  assign pending_o  = cnt_q;

endmodule

// File: rtl/irq_src_ctrl.sv
// rtl/irq_src_ctrl.sv - N independent event-to-level interrupt request lines
// Optional IRQ_SRC_MASK_EN adds mask_i, which holds off new requests per line.
module irq_src_ctrl
  import irq_src_pkg::*;
#(
  parameter int N_LINES    = DEF_N_LINES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef IRQ_SRC_MASK_EN
  input  logic [N_LINES-1:0]       mask_i,
`endif
  input  logic [N_LINES-1:0]       event_i,
  input  logic [N_LINES-1:0]       clear_i,
  input  logic [N_LINES-1:0]       int_fin_i,
  output logic [N_LINES-1:0]       int_req_o,
  output logic [N_LINES-1:0]       overflow_o,
  output logic [N_LINES*CNT_W-1:0] pending_o
);

  logic [N_LINES-1:0] mask_w;

`ifdef IRQ_SRC_MASK_EN
  assign mask_w = mask_i;
`else
  assign mask_w = '0;
`endif

  for (genvar n = 0; n < N_LINES; n++) begin : g_line
    irq_src_line #(
      .CNT_W      (CNT_W),
      .GAP_CYCLES (GAP_CYCLES)
    ) u_line (
      .clk        (clk),
      .rst        (rst),
      .event_i    (event_i[n]),
      .clear_i    (clear_i[n]),
      .int_fin_i  (int_fin_i[n]),
      .mask_i     (mask_w[n]),
      .int_req_o  (int_req_o[n]),
      .overflow_o (overflow_o[n]),
      .pending_o  (pending_o[n*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_irq_src_ctrl.sv
// tb/tb_irq_src_ctrl.sv - self-checking bench for irq_src_ctrl against a behavioural line model
module tb_irq_src_ctrl;

  localparam int N   = 8;
  localparam int CW  = 4;
  localparam int GAP = 2;
  localparam int MAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    event_i, clear_i, int_fin_i, mask_v;
  logic [N-1:0]    int_req_o, overflow_o;
  logic [N*CW-1:0] pending_o;

  int vec  = 0;
  int miss = 0;

  int           m_cnt [N];
  bit           m_req [N];
  int           m_low [N];
  bit           m_ovf [N];
  logic [N-1:0]    e_req, e_ovf;
  logic [N*CW-1:0] e_pend;

  always #5 clk = ~clk;

  irq_src_ctrl #(.N_LINES(N), .CNT_W(CW), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef IRQ_SRC_MASK_EN
    .mask_i     (mask_v),
`endif
    .event_i    (event_i),
    .clear_i    (clear_i),
    .int_fin_i  (int_fin_i),
    .int_req_o  (int_req_o),
    .overflow_o (overflow_o),
    .pending_o  (pending_o)
  );

  task automatic model_pack();
    for (int n = 0; n < N; n++) begin
      e_req[n] = m_req[n];
      e_ovf[n] = m_ovf[n];
      e_pend[n*CW +: CW] = CW'(m_cnt[n]);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < N; n++) begin
      m_cnt[n] = 0; m_req[n] = 0; m_low[n] = 0; m_ovf[n] = 0;
    end
    model_pack();
  endtask

  // Request stays up until a fin; then exactly GAP low cycles before it may re-rise.
  task automatic model_step(input logic [N-1:0] ev, clr, fin);
    bit acc;
    bit blk;
    for (int n = 0; n < N; n++) begin
      blk = 1'b0;
`ifdef IRQ_SRC_MASK_EN
      blk = mask_v[n];
`endif
      if (clr[n]) begin
        m_cnt[n] = 0; m_req[n] = 0; m_low[n] = 0; m_ovf[n] = 0;
      end else begin
        acc = m_req[n] && fin[n];
        if (ev[n] && !acc && m_cnt[n] == MAX) m_ovf[n] = 1;
        else m_cnt[n] = m_cnt[n] + int'(ev[n]) - int'(acc);
        if (m_req[n]) begin
          if (acc) begin m_req[n] = 0; m_low[n] = GAP; end
        end else if (m_low[n] > 0) begin
          m_low[n]--;
          if (m_low[n] == 0 && m_cnt[n] > 0 && !blk) m_req[n] = 1;
        end else if (m_cnt[n] > 0 && !blk) begin
          m_req[n] = 1;
        end
      end
    end
    model_pack();
  endtask

  task automatic cyc(input logic [N-1:0] ev, clr, fin);
    event_i = ev; clear_i = clr; int_fin_i = fin;
    @(posedge clk);
    model_step(ev, clr, fin);
    #1;
    event_i = '0; clear_i = '0; int_fin_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; event_i = '1; clear_i = '0; int_fin_i = '1; mask_v = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if (int_req_o !== '0 || overflow_o !== '0 || pending_o !== '0) begin
      miss++;
      $display("FAIL reset: req=%h ovf=%h pend=%h required all zero", int_req_o, overflow_o, pending_o);
    end
    event_i = '0; int_fin_i = '0;
    rst = 1'b0;
  endtask

  task automatic test_single_event();
    cyc(8'h01, '0, '0);
    vec++;
    if (int_req_o[0] !== 1'b1 || pending_o[3:0] !== 4'd1) begin
      miss++;
      $display("FAIL single_rise: req0=%b pend0=%0d required 1/1", int_req_o[0], pending_o[3:0]);
    end
    for (int c = 0; c < 8; c++) begin
      cyc('0, '0, (c == 3) ? 8'h01 : 8'h00);
      vec++;
      if (int_req_o !== e_req || overflow_o !== e_ovf || pending_o !== e_pend) begin
        miss++;
        $display("FAIL single c%0d: req=%h/%h ovf=%h/%h pend=%h/%h", c, int_req_o, e_req, overflow_o, e_ovf, pending_o, e_pend);
      end
    end
    vec++;
    if (int_req_o[0] !== 1'b0 || pending_o[3:0] !== 4'd0) begin
      miss++;
      $display("FAIL single_end: req0=%b pend0=%0d required 0/0", int_req_o[0], pending_o[3:0]);
    end
  endtask

  task automatic test_queued();
    for (int k = 0; k < 4; k++) cyc(8'h04, '0, '0);
    vec++;
    if (pending_o[11:8] !== 4'd4 || int_req_o[2] !== 1'b1) begin
      miss++;
      $display("FAIL queued_fill: pend2=%0d req2=%b required 4/1", pending_o[11:8], int_req_o[2]);
    end
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++) begin
        cyc('0, '0, (c == 0) ? 8'h04 : 8'h00);
        vec++;
        if (int_req_o[2] !== ((c == 2) && (k < 3)) || pending_o !== e_pend || int_req_o !== e_req) begin
          miss++;
          $display("FAIL queued k%0d c%0d: req=%h/%h pend=%h/%h", k, c, int_req_o, e_req, pending_o, e_pend);
        end
      end
    end
    vec++;
    if (pending_o[11:8] !== 4'd0 || int_req_o[2] !== 1'b0) begin
      miss++;
      $display("FAIL queued_end: pend2=%0d req2=%b required 0/0", pending_o[11:8], int_req_o[2]);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 17; k++) cyc(8'h02, '0, '0);
    vec++;
    if (pending_o[7:4] !== 4'd15 || overflow_o[1] !== 1'b1) begin
      miss++;
      $display("FAIL sat_fill: pend1=%0d ovf1=%b required 15/1", pending_o[7:4], overflow_o[1]);
    end
    cyc('0, 8'h02, '0);
    for (int k = 0; k < 15; k++) cyc(8'h02, '0, '0);
    vec++;
    if (pending_o[7:4] !== 4'd15 || overflow_o[1] !== 1'b0) begin
      miss++;
      $display("FAIL sat_exact: pend1=%0d ovf1=%b required 15/0", pending_o[7:4], overflow_o[1]);
    end
    cyc(8'h02, '0, 8'h02);
    vec++;
    if (pending_o[7:4] !== 4'd15 || overflow_o[1] !== 1'b0 || int_req_o[1] !== 1'b0) begin
      miss++;
      $display("FAIL sat_evfin: pend1=%0d ovf1=%b req1=%b required 15/0/0", pending_o[7:4], overflow_o[1], int_req_o[1]);
    end
    cyc('0, 8'h02, '0);
  endtask

  task automatic test_clear();
    cyc(8'h08, '0, '0);
    cyc(8'h08, 8'h08, 8'h08);
    vec++;
    if (int_req_o[3] !== 1'b0 || pending_o[15:12] !== 4'd0 || overflow_o[3] !== 1'b0 || pending_o !== e_pend) begin
      miss++;
      $display("FAIL clear: req3=%b pend3=%0d ovf3=%b required 0/0/0", int_req_o[3], pending_o[15:12], overflow_o[3]);
    end
  endtask

  task automatic test_spurious_and_async_reset();
    cyc('0, '0, 8'h10);
    vec++;
    if (int_req_o[4] !== 1'b0 || pending_o[19:16] !== 4'd0 || int_req_o !== e_req) begin
      miss++;
      $display("FAIL spurious_fin: req4=%b pend4=%0d required 0/0", int_req_o[4], pending_o[19:16]);
    end
    cyc(8'h10, '0, '0);
    cyc(8'h10, '0, '0);
    cyc('0, '0, 8'h10);
    vec++;
    if (int_req_o[4] !== 1'b0 || pending_o[19:16] !== 4'd1) begin
      miss++;
      $display("FAIL gap_entry: req4=%b pend4=%0d required 0/1", int_req_o[4], pending_o[19:16]);
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    vec++;
    if (int_req_o !== '0 || overflow_o !== '0 || pending_o !== '0) begin
      miss++;
      $display("FAIL async_reset: req=%h ovf=%h pend=%h required all zero", int_req_o, overflow_o, pending_o);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    cyc('0, '0, '0);
    vec++;
    if (int_req_o !== '0 || pending_o !== '0) begin
      miss++;
      $display("FAIL post_reset: req=%h pend=%h required zero", int_req_o, pending_o);
    end
  endtask

`ifdef IRQ_SRC_MASK_EN
  task automatic test_mask();
    mask_v = 8'h20;
    cyc(8'h20, '0, '0);
    cyc(8'h20, '0, '0);
    cyc('0, '0, '0);
    vec++;
    if (pending_o[23:20] !== 4'd2 || int_req_o[5] !== 1'b0) begin
      miss++;
      $display("FAIL mask_hold: pend5=%0d req5=%b required 2/0", pending_o[23:20], int_req_o[5]);
    end
    mask_v = '0;
    cyc('0, '0, '0);
    vec++;
    if (int_req_o[5] !== 1'b1 || pending_o[23:20] !== 4'd2) begin
      miss++;
      $display("FAIL mask_release: req5=%b pend5=%0d required 1/2", int_req_o[5], pending_o[23:20]);
    end
    cyc('0, 8'h20, '0);
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] ev, clr, fin;
    for (int c = 0; c < 600; c++) begin
      ev  = N'($urandom);
      fin = N'($urandom & $urandom);
      clr = ($urandom_range(0, 19) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      cyc(ev, clr, fin);
      vec++;
      if (int_req_o !== e_req || overflow_o !== e_ovf || pending_o !== e_pend) begin
        miss++;
        $display("FAIL random c%0d: req=%h/%h ovf=%h/%h pend=%h/%h", c, int_req_o, e_req, overflow_o, e_ovf, pending_o, e_pend);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_queued();
    test_saturation();
    test_clear();
    test_spurious_and_async_reset();
`ifdef IRQ_SRC_MASK_EN
    test_mask();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/irq_src_ctrl.md
Name: irq_src_ctrl

Overview:
- Peripheral-side end of the daisy-chain interrupt interface.
- Converts single-cycle event pulses from a peripheral into level interrupt requests (int_req) that the interrupt controller consumes.
- Holds each request until the controller returns the matching completion strobe (int_fin).
- Counts events that arrive while a request is in service, and forces a low gap between successive requests so the controller's edge detector sees every request.

Parameters:
- N_LINES, 8, number of independent interrupt lines (1..32); bit n maps to controller request bit n.
- CNT_W, 4, width of each per-line pending-event counter; saturates at 2^CNT_W-1.
- GAP_CYCLES, 2, number of cycles int_req_o[n] is held low after a completion (must be >=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- event_i  input  N_LINES  peripheral event pulses, one event per high cycle per bit.
- clear_i  input  N_LINES  synchronous per-line flush (software clear).
- int_fin_i  input  N_LINES  completion strobe from the interrupt controller, one cycle.
- int_req_o  output  N_LINES  interrupt request level to the controller.
- overflow_o  output  N_LINES  sticky flag per line; an event was lost to counter saturation.
- pending_o  output  N_LINES*CNT_W  flattened per-line outstanding-event count; line n occupies bits [n*CNT_W +: CNT_W].

Behaviour:
- Reset: all lines are put in IDLE.
  - cnt = 0, gap counter = 0.
  - int_req_o = 0, overflow_o = 0, pending_o = 0.
- Lines are fully independent. The per-line FSM has three states: IDLE, REQ, GAP.
- int_req_o[n] is registered and equals (state==REQ).
- cnt is the number of outstanding events, including the one currently being signalled.
- Counter update each cycle: cnt_next = cnt + event - (fin accepted).
  - Saturates at 2^CNT_W-1, never wraps.
  - An event that arrives with cnt at max and no accepted fin in the same cycle is dropped and sets overflow_o[n].
- IDLE:
  - If event_i[n]=1 or cnt!=0, go to REQ.
  - int_req_o[n] rises the cycle after the event's sampling edge (1-cycle latency).
- REQ:
  - int_req_o[n] is held high indefinitely.
  - If int_fin_i[n]=1, the fin is accepted: cnt decrements and the line goes to GAP with the gap counter loaded to GAP_CYCLES.
- GAP:
  - int_req_o[n] is low; the gap counter decrements each cycle.
  - When the gap counter equals 1: go to REQ if cnt_next!=0, else go to IDLE.
  - The low phase is exactly GAP_CYCLES cycles.
- int_fin_i[n] in IDLE or GAP is ignored: no counter change, no state change.
- Event and accepted fin in the same cycle: net cnt unchanged, and the line still enters GAP.
- clear_i[n] has the highest priority.
  - Next state IDLE, cnt = 0, overflow_o[n] = 0.
  - Any simultaneous event or fin on that line is discarded.
  - A clear during REQ drops int_req_o[n] the next cycle.
- Asynchronous rst mid-operation immediately forces the reset values listed above; no pending state survives.
- pending_o reflects the registered cnt (0 latency after the edge).

Optional Feature:
- Macro: IRQ_SRC_MASK_EN.
- When defined:
  - Adds input mask_i [N_LINES].
  - mask_i[n]=1 blocks the IDLE->REQ and GAP->REQ transitions; the line waits in IDLE.
  - Events keep counting, and the request is raised when the mask clears.
  - A request already in REQ is not withdrawn by the mask.
- When undefined: no mask_i port; behaviour as above.

Decomposition:
- Package irq_src_pkg:
  - typedef enum logic [1:0] {IDLE, REQ, GAP} irq_line_state_t.
  - Default constants for N_LINES, CNT_W, GAP_CYCLES.
- Sub-module irq_src_line: one FSM, counter and overflow flag.
  - The top module instantiates it N_LINES times in a generate loop.
  - The top only flattens pending_o and routes the optional mask.

Test Plan:
- Reset and single event: rst high, then event_i[0] pulse at cycle 5.
  - int_req_o[0]=1 from cycle 6, pending_o line0 = 1.
  - int_fin_i[0] at cycle 10: int_req_o[0]=0 for cycles 11-12 (GAP_CYCLES=2), then stays 0; pending line0 = 0.
- Queued events: 3 event pulses on line 2 while in REQ (pending = 4).
  - Each fin gives exactly 2 low cycles, then int_req_o[2] re-rises.
  - After 4 fins the line is IDLE with pending 0.
- Saturation: CNT_W=4, 17 events on line 1 with no fin.
  - pending line1 = 15, overflow_o[1]=1.
  - A simultaneous event and fin at pending 15 leaves pending 15 and does not newly set overflow.
- Clear priority: clear_i[3] in the same cycle as event_i[3] and int_fin_i[3] while in REQ.
  - Next cycle int_req_o[3]=0, pending 0, overflow_o[3]=0.
- Spurious fin and async reset: int_fin_i[4] while IDLE has no effect.
  - rst asserted mid-GAP clears all outputs before the next clock edge.
- IRQ_SRC_MASK_EN: mask_i[5]=1 and 2 events give pending 2 with int_req_o[5]=0.
  - Releasing the mask raises int_req_o[5] on the next cycle.
